// File: rtl/input_mapper_pkg.sv
// input_mapper_pkg: shared control-bit layout, keymap entry fields, key FSM states and default keyboard map
//   no ports; imported by input_mapper and keymap_ram
package input_mapper_pkg;
    localparam int RIGHT = 0;
    localparam int LEFT = 1;
    localparam int DOWN = 2;
    localparam int UP = 3;
    localparam int BTN0 = 4;
    localparam int VALID = 7;
    localparam int IDX_MSB = 6;
    localparam int KM_AW = 9;
    localparam int KM_DEPTH = 512;

    typedef enum logic [1:0] {IDLE, LOOKUP, APPLY} km_state_e;

    function automatic int start_bit(input int buttons);
        return BTN0 + buttons;
    endfunction

    function automatic int coin_bit(input int buttons);
        return BTN0 + buttons + 1;
    endfunction

    function automatic int pause_bit(input int buttons);
        return BTN0 + buttons + 2;
    endfunction

    function automatic int joy_w(input int buttons);
        return 7 + buttons;
    endfunction

    // Arrows and Alt match with or without the E0 prefix; everything else only unprefixed.
    // Buttons beyond the configured count map to an invalid entry.
    function automatic logic [7:0] default_map(input logic ext, input logic [7:0] code, input int buttons);
        int p2;
        int idx;
        p2 = joy_w(buttons);
        case (code)
            8'h75: idx = UP;
            8'h72: idx = DOWN;
            8'h6B: idx = LEFT;
            8'h74: idx = RIGHT;
            8'h11: idx = buttons > 1 ? BTN0 + 1 : -1;
            default: idx = -1;
        endcase
        if (!ext) begin
            case (code)
                8'h14: idx = buttons > 0 ? BTN0 : -1;
                8'h29: idx = buttons > 2 ? BTN0 + 2 : -1;
                8'h16: idx = start_bit(buttons);
                8'h2E: idx = coin_bit(buttons);
                8'h4D: idx = pause_bit(buttons);
                8'h2D: idx = p2 + UP;
                8'h2B: idx = p2 + DOWN;
                8'h23: idx = p2 + LEFT;
                8'h34: idx = p2 + RIGHT;
                8'h1C: idx = buttons > 0 ? p2 + BTN0 : -1;
                8'h1B: idx = buttons > 1 ? p2 + BTN0 + 1 : -1;
                8'h15: idx = buttons > 2 ? p2 + BTN0 + 2 : -1;
                8'h1E: idx = p2 + start_bit(buttons);
                8'h36: idx = p2 + coin_bit(buttons);
                default: ;
            endcase
        end
        return (idx < 0 || idx > 127) ? 8'h00 : {1'b1, idx[6:0]};
    endfunction
endpackage

// File: rtl/keymap_ram.sv
// keymap_ram: 512 x 8 single-port synchronous RAM, one read or one write per clock
//   clk   in   clock
//   we    in   write enable (no read that cycle)
//   addr  in   {ext, code}
//   wdata in   entry to write
//   rdata out  registered read data
module keymap_ram
    import input_mapper_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [KM_AW-1:0] addr,
    input  logic [7:0]       wdata,
    output logic [7:0]       rdata
);
    logic [7:0] mem_q [KM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[addr] <= wdata;
        else rdata <= mem_q[addr];
    end
endmodule

// File: rtl/input_mapper.sv
// input_mapper: merges PS/2 keys and joysticks into per-player controls, with DIP banks, coin stretch and pause toggle
//   clk, reset            clock, asynchronous active-high reset
//   ps2_key               key event {toggle, pressed, ext, code}
//   joystick              per-player joystick vectors, player 0 in LSBs
//   ioctl_addr/data/wr/index  download port for keymap and DIP banks
//   ctrl                  registered merged controls
//   dip                   DIP banks, bank 0 in LSBs
//   pause                 latched pause state
module input_mapper
    import input_mapper_pkg::*;
#(
    parameter int PLAYERS = 2,
    parameter int BUTTONS = 3,
    parameter int DIP_BANKS = 8,
    parameter int COIN_MIN = 960000,
    parameter int KEYMAP_INDEX = 253,
    parameter int DIP_INDEX = 254
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [10:0]                    ps2_key,
    input  logic [PLAYERS*(7+BUTTONS)-1:0] joystick,
    input  logic [24:0]                    ioctl_addr,
    input  logic [7:0]                     ioctl_data,
    input  logic                           ioctl_wr,
    input  logic [7:0]                     ioctl_index,
    output logic [PLAYERS*(7+BUTTONS)-1:0] ctrl,
    output logic [DIP_BANKS*8-1:0]         dip,
    output logic                           pause
);
    localparam int JOY_W = joy_w(BUTTONS);
    localparam int N = PLAYERS * JOY_W;
    localparam int COIN = coin_bit(BUTTONS);
    localparam int PAUSE = pause_bit(BUTTONS);
    localparam int CW = $clog2(COIN_MIN + 1);

    km_state_e state_q, state_d;
    logic init_q, old_q, toggle, km_wr, dip_wr;
    logic pressed_q, pressed_d, pend_q, pend_d, pend_pressed_q, pend_pressed_d;
    logic [KM_AW-1:0] addr_q, addr_d, pend_addr_q, pend_addr_d;
    logic map_loaded_q, pause_q, pause_prev_q, pause_any;
    logic [N-1:0] key_q, key_d, raw, mask, coin_ext, ctrl_q, ctrl_d;
    logic [7:0] ram_rdata, entry;
    logic [PLAYERS-1:0] pause_bits;

    // init_q masks the first clock after reset so old_q can pick up the current toggle level.
    assign toggle = init_q && (ps2_key[10] != old_q);
    assign km_wr = ioctl_wr && ioctl_index == 8'(KEYMAP_INDEX) && ioctl_addr[24:KM_AW] == '0;
    assign dip_wr = ioctl_wr && ioctl_index == 8'(DIP_INDEX) && 32'(ioctl_addr) < DIP_BANKS;
    assign raw = key_q | joystick;
    assign entry = map_loaded_q ? ram_rdata : default_map(addr_q[8], addr_q[7:0], BUTTONS);
    assign mask = N'(1) << entry[IDX_MSB:0];
    assign pause_any = |pause_bits;
    assign ctrl_d = raw | coin_ext;
    assign ctrl = ctrl_q;
    assign pause = pause_q;

    // Downloads own the RAM port; a lookup in the same cycle simply waits in LOOKUP.
    keymap_ram u_ram (
        .clk  (clk),
        .we   (km_wr),
        .addr (km_wr ? ioctl_addr[KM_AW-1:0] : addr_q),
        .wdata(ioctl_data),
        .rdata(ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        pressed_d = pressed_q;
        addr_d = addr_q;
        pend_d = pend_q;
        pend_pressed_d = pend_pressed_q;
        pend_addr_d = pend_addr_q;
        key_d = key_q;
        if (toggle && (state_q != IDLE || pend_q)) begin
            pend_d = 1'b1;
            pend_pressed_d = ps2_key[9];
            pend_addr_d = ps2_key[8:0];
        end
        // A held event is serviced first; a fresh toggle in the same cycle takes its place.
        if (state_q == IDLE && (pend_q || toggle)) begin
            state_d = LOOKUP;
            pressed_d = pend_q ? pend_pressed_q : ps2_key[9];
            addr_d = pend_q ? pend_addr_q : ps2_key[8:0];
            pend_d = pend_q && toggle;
        end
        if (state_q == LOOKUP && !km_wr) state_d = APPLY;
        if (state_q == APPLY) begin
            state_d = IDLE;
            if (entry[VALID] && 32'(entry[IDX_MSB:0]) < N) key_d = pressed_q ? key_q | mask : key_q & ~mask;
        end
        if (km_wr) key_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            init_q <= 1'b0;
            old_q <= 1'b0;
            pressed_q <= 1'b0;
            addr_q <= '0;
            pend_q <= 1'b0;
            pend_pressed_q <= 1'b0;
            pend_addr_q <= '0;
            map_loaded_q <= 1'b0;
            key_q <= '0;
            ctrl_q <= '0;
            pause_q <= 1'b0;
            pause_prev_q <= 1'b0;
        end else begin
            state_q <= state_d;
            init_q <= 1'b1;
            old_q <= ps2_key[10];
            pressed_q <= pressed_d;
            addr_q <= addr_d;
            pend_q <= pend_d;
            pend_pressed_q <= pend_pressed_d;
            pend_addr_q <= pend_addr_d;
            map_loaded_q <= map_loaded_q | km_wr;
            key_q <= key_d;
            ctrl_q <= ctrl_d;
            pause_prev_q <= pause_any;
            pause_q <= pause_q ^ (pause_any & ~pause_prev_q);
        end
    end

    for (genvar p = 0; p < PLAYERS; p++) begin : g_coin
        logic [CW-1:0] cnt_q;
        logic prev_q;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_q <= '0;
                prev_q <= 1'b0;
            end else begin
                prev_q <= raw[p*JOY_W+COIN];
                cnt_q <= raw[p*JOY_W+COIN] && !prev_q ? CW'(COIN_MIN - 1) : cnt_q != '0 ? cnt_q - CW'(1) : cnt_q;
            end
        end
        assign coin_ext[p*JOY_W +: JOY_W] = JOY_W'(cnt_q != '0) << COIN;
        assign pause_bits[p] = raw[p*JOY_W+PAUSE];
    end

    for (genvar b = 0; b < DIP_BANKS; b++) begin : g_dip
        logic [7:0] bank_q;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) bank_q <= '0;
            else if (dip_wr && ioctl_addr == 25'(b)) bank_q <= ioctl_data;
        end
        assign dip[b*8 +: 8] = bank_q;
    end
endmodule

// File: tb/tb_input_mapper.sv
// tb_input_mapper: directed self-checking bench for input_mapper
module tb_input_mapper;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [10:0] ps2_key;
    logic [19:0] joystick;
    logic [24:0] ioctl_addr;
    logic [7:0] ioctl_data;
    logic ioctl_wr;
    logic [7:0] ioctl_index;
    logic [19:0] ctrl;
    logic [63:0] dip;
    logic pause;
    int passed = 0;
    int total = 0;

    input_mapper #(
        .PLAYERS(2), .BUTTONS(3), .DIP_BANKS(8), .COIN_MIN(16), .KEYMAP_INDEX(253), .DIP_INDEX(254)
    ) dut (
        .clk(clk), .reset(reset), .ps2_key(ps2_key), .joystick(joystick),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index),
        .ctrl(ctrl), .dip(dip), .pause(pause)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic key(input logic p, input logic e, input logic [7:0] c);
        ps2_key = {~ps2_key[10], p, e, c};
    endtask

    task automatic ioctl_write(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
        ioctl_index = idx;
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr = 1'b1;
        step(1);
        ioctl_wr = 1'b0;
    endtask

    task automatic test_reset;
        ps2_key = {1'b1, 1'b1, 1'b0, 8'h75};
        joystick = '0;
        ioctl_addr = '0;
        ioctl_data = '0;
        ioctl_wr = 1'b0;
        ioctl_index = '0;
        step(2);
        total++; if (ctrl !== 20'h0) $display("FAIL reset_ctrl got=%h want=%h", ctrl, 20'h0); else passed++;
        total++; if (dip !== 64'h0) $display("FAIL reset_dip got=%h want=%h", dip, 64'h0); else passed++;
        total++; if (pause !== 1'b0) $display("FAIL reset_pause got=%b want=0", pause); else passed++;
        reset = 1'b0;
        step(6);
        total++; if (ctrl !== 20'h0) $display("FAIL no_phantom_key got=%h want=%h", ctrl, 20'h0); else passed++;
    endtask

    task automatic test_default_map;
        key(1, 0, 8'h75); step(3);
        total++; if (ctrl !== 20'h0) $display("FAIL up_before_4th_edge got=%h want=%h", ctrl, 20'h0); else passed++;
        step(1);
        total++; if (ctrl !== 20'h00008) $display("FAIL up_on_4th_edge got=%h want=%h", ctrl, 20'h00008); else passed++;
        key(0, 0, 8'h75); step(4);
        total++; if (ctrl !== 20'h0) $display("FAIL up_release got=%h want=%h", ctrl, 20'h0); else passed++;
        key(1, 1, 8'h6B); step(4);
        total++; if (ctrl !== 20'h00002) $display("FAIL ext_left got=%h want=%h", ctrl, 20'h00002); else passed++;
        key(0, 1, 8'h6B); step(4);
        key(1, 1, 8'h14); step(4);
        total++; if (ctrl !== 20'h0) $display("FAIL ext_unmapped got=%h want=%h", ctrl, 20'h0); else passed++;
        key(0, 1, 8'h14); step(4);
        key(1, 0, 8'h34); step(4);
        total++; if (ctrl !== 20'h00400) $display("FAIL p2_right got=%h want=%h", ctrl, 20'h00400); else passed++;
        key(0, 0, 8'h34); step(4);
        total++; if (ctrl !== 20'h0) $display("FAIL p2_right_release got=%h want=%h", ctrl, 20'h0); else passed++;
    endtask

    task automatic test_joystick;
        joystick = 20'h00011; step(1);
        total++; if (ctrl !== 20'h00011) $display("FAIL joy_latency got=%h want=%h", ctrl, 20'h00011); else passed++;
        joystick = '0; step(1);
        total++; if (ctrl !== 20'h0) $display("FAIL joy_release got=%h want=%h", ctrl, 20'h0); else passed++;
        key(1, 0, 8'h75); step(4);
        joystick = 20'h00008; step(1);
        total++; if (ctrl !== 20'h00008) $display("FAIL or_both got=%h want=%h", ctrl, 20'h00008); else passed++;
        key(0, 0, 8'h75); step(4);
        total++; if (ctrl !== 20'h00008) $display("FAIL key_release_joy_held got=%h want=%h", ctrl, 20'h00008); else passed++;
        joystick = '0; step(1);
        total++; if (ctrl !== 20'h0) $display("FAIL both_released got=%h want=%h", ctrl, 20'h0); else passed++;
    endtask

    task automatic test_pause;
        joystick = 20'h80000; step(1);
        total++; if (pause !== 1'b1) $display("FAIL pause_first got=%b want=1", pause); else passed++;
        total++; if (ctrl !== 20'h80000) $display("FAIL pause_bit_in_ctrl got=%h want=%h", ctrl, 20'h80000); else passed++;
        joystick = '0; step(2);
        total++; if (pause !== 1'b1) $display("FAIL pause_latched got=%b want=1", pause); else passed++;
        joystick = 20'h80000; step(1);
        joystick = '0; step(1);
        total++; if (pause !== 1'b0) $display("FAIL pause_second got=%b want=0", pause); else passed++;
        joystick = 20'h80200; step(3);
        total++; if (pause !== 1'b1) $display("FAIL pause_both_single got=%b want=1", pause); else passed++;
        joystick = '0; step(1);
        joystick = 20'h00200; step(1);
        joystick = '0; step(1);
        total++; if (pause !== 1'b0) $display("FAIL pause_restore got=%b want=0", pause); else passed++;
    endtask

    task automatic test_coin;
        int cnt;
        int last;
        joystick = 20'h00100; step(1);
        joystick = '0;
        cnt = 0;
        for (int i = 0; i < 24; i++) begin
            if (ctrl[8]) cnt++;
            step(1);
        end
        total++; if (cnt !== 16) $display("FAIL coin_single_width got=%0d want=16", cnt); else passed++;
        joystick = 20'h00100; step(1);
        joystick = '0;
        cnt = 0;
        last = -1;
        for (int i = 0; i < 40; i++) begin
            if (ctrl[8]) begin
                cnt++;
                last = i;
            end
            if (i == 9) joystick = 20'h00100;
            step(1);
            joystick = '0;
        end
        total++; if (cnt !== 26) $display("FAIL coin_retrigger_width got=%0d want=26", cnt); else passed++;
        total++; if (last !== 25) $display("FAIL coin_retrigger_last got=%0d want=25", last); else passed++;
    endtask

    task automatic test_dip;
        ioctl_write(8'd254, 25'd1, 8'hA5);
        total++; if (dip !== 64'h0000_0000_0000_A500) $display("FAIL dip_bank1 got=%h want=%h", dip, 64'h0000_0000_0000_A500); else passed++;
        ioctl_write(8'd254, 25'd9, 8'hFF);
        total++; if (dip !== 64'h0000_0000_0000_A500) $display("FAIL dip_addr9_ignored got=%h want=%h", dip, 64'h0000_0000_0000_A500); else passed++;
        ioctl_write(8'd0, 25'd2, 8'h77);
        ioctl_write(8'd254, 25'd7, 8'h3C);
        total++; if (dip !== 64'h3C00_0000_0000_A500) $display("FAIL dip_bank7 got=%h want=%h", dip, 64'h3C00_0000_0000_A500); else passed++;
    endtask

    task automatic test_keymap_load;
        key(1, 0, 8'h29); step(4);
        total++; if (ctrl !== 20'h00040) $display("FAIL default_b2_held got=%h want=%h", ctrl, 20'h00040); else passed++;
        ioctl_write(8'd253, 25'h029, 8'h8F);
        step(1);
        total++; if (ctrl !== 20'h0) $display("FAIL held_key_cleared got=%h want=%h", ctrl, 20'h0); else passed++;
        ioctl_write(8'd253, 25'h075, 8'h83);
        ioctl_write(8'd253, 25'h172, 8'h8D);
        ioctl_write(8'd253, 25'h01C, 8'h0E);
        ioctl_write(8'd253, 25'h01B, 8'hFF);
        ioctl_write(8'd253, 25'h100, 8'h00);
        key(1, 0, 8'h29); step(3);
        total++; if (ctrl !== 20'h0) $display("FAIL loaded_before_4th_edge got=%h want=%h", ctrl, 20'h0); else passed++;
        step(1);
        total++; if (ctrl !== 20'h08000) $display("FAIL loaded_p2_b1 got=%h want=%h", ctrl, 20'h08000); else passed++;
        key(0, 0, 8'h29); step(4);
        key(1, 0, 8'h1C); step(4);
        total++; if (ctrl !== 20'h0) $display("FAIL invalid_entry got=%h want=%h", ctrl, 20'h0); else passed++;
        key(0, 0, 8'h1C); step(4);
        key(1, 0, 8'h1B); step(4);
        total++; if (ctrl !== 20'h0) $display("FAIL index_out_of_range got=%h want=%h", ctrl, 20'h0); else passed++;
        key(0, 0, 8'h1B); step(4);
        key(1, 1, 8'h72); step(4);
        total++; if (ctrl !== 20'h02000) $display("FAIL loaded_ext got=%h want=%h", ctrl, 20'h02000); else passed++;
        key(0, 1, 8'h72); step(4);
    endtask

    task automatic test_collision;
        key(1, 0, 8'h75); step(1);
        ioctl_write(8'd253, 25'h100, 8'h00);
        step(2);
        total++; if (ctrl !== 20'h0) $display("FAIL stall_not_on_4th got=%h want=%h", ctrl, 20'h0); else passed++;
        step(1);
        total++; if (ctrl !== 20'h00008) $display("FAIL stall_on_5th got=%h want=%h", ctrl, 20'h00008); else passed++;
        key(0, 0, 8'h75); step(4);
        total++; if (ctrl !== 20'h0) $display("FAIL stall_release got=%h want=%h", ctrl, 20'h0); else passed++;
        key(1, 0, 8'h29); step(1);
        key(1, 1, 8'h72); step(10);
        total++; if (ctrl !== 20'h0A000) $display("FAIL back_to_back_press got=%h want=%h", ctrl, 20'h0A000); else passed++;
        key(0, 0, 8'h29); step(1);
        key(0, 1, 8'h72); step(10);
        total++; if (ctrl !== 20'h0) $display("FAIL back_to_back_release got=%h want=%h", ctrl, 20'h0); else passed++;
    endtask

    task automatic test_reset_mid;
        joystick = 20'h00200; step(1);
        joystick = 20'h00001;
        key(1, 0, 8'h75); step(1);
        total++; if (pause !== 1'b1) $display("FAIL pre_reset_pause got=%b want=1", pause); else passed++;
        total++; if (ctrl !== 20'h00001) $display("FAIL pre_reset_ctrl got=%h want=%h", ctrl, 20'h00001); else passed++;
        #2 reset = 1'b1;
        #1;
        total++; if (ctrl !== 20'h0) $display("FAIL async_reset_ctrl got=%h want=%h", ctrl, 20'h0); else passed++;
        total++; if (dip !== 64'h0) $display("FAIL async_reset_dip got=%h want=%h", dip, 64'h0); else passed++;
        total++; if (pause !== 1'b0) $display("FAIL async_reset_pause got=%b want=0", pause); else passed++;
        step(1);
        reset = 1'b0;
        joystick = '0;
        step(6);
        total++; if (ctrl !== 20'h0) $display("FAIL fsm_idle_after_reset got=%h want=%h", ctrl, 20'h0); else passed++;
        key(1, 0, 8'h29); step(4);
        total++; if (ctrl !== 20'h00040) $display("FAIL default_map_after_reset got=%h want=%h", ctrl, 20'h00040); else passed++;
        key(0, 0, 8'h29); step(4);
        total++; if (ctrl !== 20'h0) $display("FAIL final_release got=%h want=%h", ctrl, 20'h0); else passed++;
    endtask

    initial begin
        test_reset;
        test_default_map;
        test_joystick;
        test_pause;
        test_coin;
        test_dip;
        test_keymap_load;
        test_collision;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/input_mapper.md
# input_mapper

Parametrised player-input front end between `hps_io` and the game core. It merges PS/2 keyboard events and MiSTer joystick vectors into per-player control vectors for any number of players and buttons. The keyboard-to-control mapping is a table loadable at runtime over ioctl, with a built-in default map. The block also captures DIP switch banks, stretches coin pulses to a minimum width, and provides a latched pause toggle.

## Interface
Parameters:
- `PLAYERS`, 2: number of players.
- `BUTTONS`, 3: fire buttons per player. `JOY_W = 7 + BUTTONS`, and `PLAYERS*JOY_W` must be ≤ 128.
- `DIP_BANKS`, 8: number of 8-bit DIP banks.
- `COIN_MIN`, 960000: minimum coin high time in clocks (10 ms at 96 MHz).
- `KEYMAP_INDEX`, 253: ioctl index of the keymap download.
- `DIP_INDEX`, 254: ioctl index of the DIP download.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `ps2_key`  in  11  `hps_io` key event: [10] toggle, [9] pressed, [8] extended, [7:0] code.
- `joystick`  in  `PLAYERS*JOY_W`  per-player joystick vectors, player 0 in the LSBs.
- `ioctl_addr`  in  25  download address.
- `ioctl_data`  in  8  download byte.
- `ioctl_wr`  in  1  download write strobe.
- `ioctl_index`  in  8  download index.
- `ctrl`  out  `PLAYERS*JOY_W`  merged controls.
- `dip`  out  `DIP_BANKS*8`  DIP banks, bank 0 in the LSBs.
- `pause`  out  1  latched pause state.

## Operation
- Per-player bit layout:
  - 0 right, 1 left, 2 down, 3 up.
  - `4..3+BUTTONS` buttons.
  - Then start, coin, pause.
- Keymap: 512 × 8 RAM addressed by `{ext, code}`.
  - Entry format: bit7 valid; bits[6:0] flat control index (`player*JOY_W + bit`).
  - An invalid entry, or an index ≥ `PLAYERS*JOY_W`, is ignored.
- Keymap write: `ioctl_wr && ioctl_index==KEYMAP_INDEX && ioctl_addr<512`.
  - Writes the RAM.
  - Sets `map_loaded`.
  - Clears all key-state bits, so no key can stay stuck.
- Until `map_loaded`, a combinational default map supplies entries. It uses non-extended codes, except arrows and Alt, which match both the extended and non-extended form.
  - P1: 75 up, 72 down, 6B left, 74 right, 14 b0, 11 b1, 29 b2, 16 start, 2E coin, 4D pause.
  - P2: 2D up, 2B down, 23 left, 34 right, 1C b0, 1B b1, 15 b2, 1E start, 36 coin.
- Key event FSM, states IDLE → LOOKUP → APPLY → IDLE:
  - IDLE: a toggle of `ps2_key[10]` against the registered `old_state` captures `pressed` and the address, then moves to LOOKUP.
  - LOOKUP: reads the RAM, or the default map.
  - APPLY: sets or clears one key-state bit.
- Priority: an ioctl keymap write owns the RAM port. A LOOKUP coinciding with it stalls one cycle in LOOKUP.
- A toggle arriving while the FSM is busy is not lost. It is held in a one-deep pending register and serviced on return to IDLE.
- Merge: `raw = key_state | joystick`, then registered into `ctrl`.
- Coin stretch, per player: a rising edge of the raw coin bit loads a counter with `COIN_MIN-1`. The `ctrl` coin bit stays high while the counter is nonzero or the raw bit is high. A new edge during the count reloads the counter.
- Pause: a rising edge of OR(all raw pause bits) toggles `pause`. Per-player pause bits also appear unmodified in `ctrl`.
- DIP write: `ioctl_index==DIP_INDEX && ioctl_addr < DIP_BANKS` writes bank `ioctl_addr`. Other addresses are ignored.

## Timing
- Reset: `ctrl`=0, `dip`=0, `pause`=0, key state 0, `map_loaded`=0, FSM IDLE, pending clear, coin counters 0. `old_state` takes `ps2_key[10]` at the first clock after reset. RAM contents are not reset.
- Reset mid-download: `map_loaded` clears, so the default map applies again.
- Joystick latency: `joystick` → `ctrl` in 1 clock.
- Key latency: `ctrl` updates on the 4th rising edge after `ps2_key[10]` toggles (sample, LOOKUP, APPLY, output register), plus 1 per stall cycle.
- Coin: `ctrl` coin goes high 1 clock after the raw edge and stays high for exactly `COIN_MIN` clocks after a 1-clock raw pulse.
- DIP and keymap writes take effect on the clock edge of `ioctl_wr`.
- Simultaneous key press and joystick press of the same bit: the bit is OR'd, and release of one source leaves the bit high.

## Structure
- Package `input_mapper_pkg` holds:
  - the bit-offset constants (RIGHT..PAUSE, as functions of `BUTTONS`);
  - the keymap entry fields (VALID=7, IDX=6:0);
  - the FSM state enum;
  - the `default_map(ext, code)` function.
- Sub-module `keymap_ram`: 512 × 8 single-port synchronous RAM, one read or write per clock.
- Coin stretch is a generate loop in the top. No separate module.

## Test plan
- Default map, no download: toggle with code 0x75, pressed=1 → `ctrl[3]`=1 on the 4th edge; release → 0.
- Keymap load: write addr 0x029 = 0x8F (P2 bit 5, b1), then press 0x29 → `ctrl[15]`=1 and `ctrl[6]` stays 0. A key held during the load is cleared.
- Collision: keymap write on the LOOKUP cycle → one stall, and the update arrives on the 5th edge. A second toggle 1 clock after the first → both keys applied.
- Coin: `COIN_MIN`=16, one-clock joystick coin pulse → `ctrl[8]` high for exactly 16 clocks. A second pulse at clock 10 → high until clock 26.
- Pause: press and release P2 pause twice → `pause` goes 1, then 0. Pressing P1 and P2 pause together produces a single toggle.
- DIP and reset: write index 254 addr 1 = 0xA5 → `dip[15:8]`=A5. Addr 9 is ignored. Reset asserted mid-key-event → all outputs 0 asynchronously and FSM IDLE.
